riscv_id: RTL and testbench

RISCV_ID -- requirements
Module: riscv_id

---
 rtl/riscv_id.sv | 106 ++++++++++
 tb/tb_riscv_id.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/riscv_id.sv
// RV32I instruction decode stage: one-cycle registered decode into the ID/EX slot,
// with load-use stall detection and EX-redirect squash.
module riscv_id (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   input  logic [31:0] instr,
   input  logic        flush,
   output logic        bubble,
   output logic        valid,
   output logic [31:0] pc_out,
   output logic [6:0]  opcode,
   output logic [4:0]  rd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic [31:0] imm,
   output logic        illegal
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   logic [6:0]  opc_d;
   logic        legal_d;
   logic        uses_rs1;
   logic        uses_rs2;
   logic [31:0] imm_d;
   logic        hazard;

   assign opc_d = instr[6:0];

   always_comb begin
      legal_d  = 1'b1;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      imm_d    = 32'h0;
      case (opc_d)
         OPC_LUI, OPC_AUIPC: imm_d = {instr[31:12], 12'b0};
         OPC_JAL:
            imm_d = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
            uses_rs1 = 1'b1;
            imm_d    = {{20{instr[31]}}, instr[31:20]};
         end
         OPC_STORE: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
            imm_d    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         end
         OPC_BRANCH: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
            imm_d    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         end
         OPC_OP: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         default: legal_d = 1'b0;
      endcase
   end

   // Illegal encodings clear uses_rs1/uses_rs2, so they can never raise a hazard.
   assign hazard = valid && (opcode == OPC_LOAD) && (rd != 5'd0) &&
                   ((uses_rs1 && (instr[19:15] == rd)) ||
                    (uses_rs2 && (instr[24:20] == rd)));

   assign bubble = hazard && !flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid   <= 1'b0;
         pc_out  <= 32'h0;
         opcode  <= 7'h0;
         rd      <= 5'h0;
         rs1     <= 5'h0;
         rs2     <= 5'h0;
         funct3  <= 3'h0;
         funct7  <= 7'h0;
         imm     <= 32'h0;
         illegal <= 1'b0;
      end else begin
         // Fields always track the presented word; only valid says whether they matter.
         valid   <= !flush && !bubble;
         pc_out  <= pc_in;
         opcode  <= opc_d;
         rd      <= instr[11:7];
         rs1     <= instr[19:15];
         rs2     <= instr[24:20];
         funct3  <= instr[14:12];
         funct7  <= instr[31:25];
         imm     <= imm_d;
         illegal <= !legal_d;
      end
   end

endmodule

// File: tb/tb_riscv_id.sv
// Directed bench for riscv_id: stimulus pushes hand-computed expectations into a queue,
// a monitor pops and compares after every clock edge.
module tb_riscv_id;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in;
   logic [31:0] instr;
   logic        flush;
   logic        bubble;
   logic        valid;
   logic [31:0] pc_out;
   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm;
   logic        illegal;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string       name;
      logic [97:0] exp;
   } exp_t;

   exp_t sb[$];

   riscv_id dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .instr(instr), .flush(flush),
      .bubble(bubble), .valid(valid), .pc_out(pc_out), .opcode(opcode),
      .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
      .imm(imm), .illegal(illegal)
   );

   always #5 clk = ~clk;

   function automatic logic [97:0] dec(input logic [31:0] pc, input logic [6:0] opc,
                                       input logic [4:0] r_d, input logic [4:0] r_s1,
                                       input logic [4:0] r_s2, input logic [2:0] f3,
                                       input logic [6:0] f7, input logic [31:0] im,
                                       input logic ill);
      return {1'b1, pc, opc, r_d, r_s1, r_s2, f3, f7, im, ill};
   endfunction

   localparam logic [97:0] NOP = 98'h0;

   function automatic logic [97:0] observed();
      return {valid, pc_out, opcode, rd, rs1, rs2, funct3, funct7, imm, illegal};
   endfunction

   // Drive one instruction at the negedge, check the combinational stall, queue the edge result.
   task automatic step(input string name, input logic [31:0] pc, input logic [31:0] ins,
                       input logic fl, input logic exp_bubble, input logic [97:0] exp);
      exp_t e;
      @(negedge clk);
      pc_in = pc;
      instr = ins;
      flush = fl;
      #1;
      tests++;
      if (bubble !== exp_bubble) begin
         fails++;
         $display("FAIL %s.bubble got %0b want %0b", name, bubble, exp_bubble);
      end
      e.name = name;
      e.exp  = exp;
      sb.push_back(e);
   endtask

   initial begin : monitor
      exp_t        e;
      logic [97:0] got;
      forever begin
         @(posedge clk);
         #2;
         if (sb.size() > 0) begin
            e   = sb.pop_front();
            got = observed();
            tests++;
            if (e.exp[97] ? (got !== e.exp) : (valid !== 1'b0)) begin
               fails++;
               $display("FAIL %s.out got %h want %h", e.name, got, e.exp);
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin : stim
      rst   = 1'b0;
      pc_in = 32'h0;
      instr = 32'h0;
      flush = 1'b0;
      #3;
      tests++;
      if (observed() !== NOP || bubble !== 1'b0) begin
         fails++;
         $display("FAIL reset got %h bubble %0b want 0", observed(), bubble);
      end
      @(negedge clk);
      rst = 1'b1;

      step("addi", 32'h0, 32'h00500093, 0, 0,
           dec(32'h0, 7'h13, 5'd1, 5'd0, 5'd5, 3'd0, 7'h00, 32'h5, 0));
      step("lw_x2", 32'h4, 32'h0000A103, 0, 0,
           dec(32'h4, 7'h03, 5'd2, 5'd1, 5'd0, 3'd2, 7'h00, 32'h0, 0));
      step("add_stall", 32'h8, 32'h001101B3, 0, 1, NOP);
      step("add", 32'h8, 32'h001101B3, 0, 0,
           dec(32'h8, 7'h33, 5'd3, 5'd2, 5'd1, 3'd0, 7'h00, 32'h0, 0));
      step("lw_x0", 32'hC, 32'h00002003, 0, 0,
           dec(32'hC, 7'h03, 5'd0, 5'd0, 5'd0, 3'd2, 7'h00, 32'h0, 0));
      step("add_x0", 32'h10, 32'h00000033, 0, 0,
           dec(32'h10, 7'h33, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, 0));
      step("beq", 32'h14, 32'hFE000EE3, 0, 0,
           dec(32'h14, 7'h63, 5'd29, 5'd0, 5'd0, 3'd0, 7'h7F, 32'hFFFFFFFC, 0));
      step("lui", 32'h18, 32'h123452B7, 0, 0,
           dec(32'h18, 7'h37, 5'd5, 5'd8, 5'd3, 3'd5, 7'h09, 32'h12345000, 0));
      step("illegal", 32'h1C, 32'h0000007F, 0, 0,
           dec(32'h1C, 7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, 1));
      step("jal", 32'h20, 32'h008000EF, 0, 0,
           dec(32'h20, 7'h6F, 5'd1, 5'd0, 5'd8, 3'd0, 7'h00, 32'h8, 0));
      // rs2-only dependency: sw x5 after lw x5
      step("lw_x5", 32'h24, 32'h0000A283, 0, 0,
           dec(32'h24, 7'h03, 5'd5, 5'd1, 5'd0, 3'd2, 7'h00, 32'h0, 0));
      step("sw_stall", 32'h28, 32'hFE50AE23, 0, 1, NOP);
      step("sw", 32'h28, 32'hFE50AE23, 0, 0,
           dec(32'h28, 7'h23, 5'd28, 5'd1, 5'd5, 3'd2, 7'h7F, 32'hFFFFFFFC, 0));
      // hazard coinciding with flush
      step("lw_x2b", 32'h2C, 32'h0000A103, 0, 0,
           dec(32'h2C, 7'h03, 5'd2, 5'd1, 5'd0, 3'd2, 7'h00, 32'h0, 0));
      step("add_flush", 32'h30, 32'h001101B3, 1, 0, NOP);
      step("addi_after", 32'h40, 32'h00500093, 0, 0,
           dec(32'h40, 7'h13, 5'd1, 5'd0, 5'd5, 3'd0, 7'h00, 32'h5, 0));

      // reset asserted while a load-use stall is pending
      step("lw_x2c", 32'h44, 32'h0000A103, 0, 0,
           dec(32'h44, 7'h03, 5'd2, 5'd1, 5'd0, 3'd2, 7'h00, 32'h0, 0));
      @(negedge clk);
      pc_in = 32'h48;
      instr = 32'h001101B3;
      #1;
      tests++;
      if (bubble !== 1'b1) begin
         fails++;
         $display("FAIL pre_reset.bubble got %0b want 1", bubble);
      end
      rst = 1'b0;
      #1;
      tests++;
      if (observed() !== NOP || bubble !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset got %h bubble %0b want 0", observed(), bubble);
      end
      @(negedge clk);
      rst = 1'b1;
      step("post_reset", 32'h0, 32'h00500093, 0, 0,
           dec(32'h0, 7'h13, 5'd1, 5'd0, 5'd5, 3'd0, 7'h00, 32'h5, 0));

      repeat (3) @(negedge clk);
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
